// File: rtl/spi_wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_wb_pkg                                             |
// | Description : Shared constants and FSM state encoding for the        |
// |               SPI slave to Wishbone master bridge.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package spi_wb_pkg;

    // Frame geometry, MSB first
    localparam int HDR_BITS   = 8;
    localparam int DATA_BITS  = 16;
    localparam int DUMMY_BITS = 8;

    // Header bit selecting write (1) or read (0)
    localparam int RW_BIT = 7;

    // Read data returned when the slave never acknowledges
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // Bridge FSM state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t c_IDLE     = 3'd0;
    localparam state_t c_HDR      = 3'd1;
    localparam state_t c_WR_SHIFT = 3'd2;
    localparam state_t c_WR_BUS   = 3'd3;
    localparam state_t c_RD_BUS   = 3'd4;
    localparam state_t c_RD_DUMMY = 3'd5;
    localparam state_t c_RD_SHIFT = 3'd6;
    localparam state_t c_WAIT_CS  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_edge_sync                                          |
// | Description : Multi-stage synchroniser for the asynchronous SPI pins |
// |               plus edge detection on SCK and CS_N.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |   clk, reset          system clock, synchronous active-high reset    |
// |   sclk, cs_n, mosi    raw asynchronous SPI pins                      |
// |   sclk_rise/fall      one-clk pulses on synchronised SCK edges       |
// |   cs_fall/cs_rise     one-clk pulses on synchronised CS_N edges      |
// |   mosi_s              MOSI, delayed identically to SCK               |
// |   cs_n_s              synchronised CS_N level                        |
// +----------------------------------------------------------------------+
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s,
    output logic cs_n_s
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    // CS_N resets to its idle (high) level so reset release never looks
    // like the start of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
    assign cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
    assign cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
    assign cs_n_s    = r_cs_sync[SYNC_STAGES-1];
    // Same depth as SCK, so MOSI is valid in the cycle a rise is flagged
    assign mosi_s    = r_mosi_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_wb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_wb_bridge                                          |
// | Description : SPI mode-0 slave that turns each frame into one        |
// |               classic single-beat Wishbone cycle; read data is       |
// |               returned on MISO.                                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |   clk, reset            system clock, synchronous active-high reset  |
// |   sclk, cs_n, mosi      SPI inputs (asynchronous to clk)             |
// |   miso, miso_oe         SPI data out and its output enable           |
// |   WE_O CYC_O STB_O      Wishbone master controls                     |
// |   ADR_O DAT_O DAT_I     Wishbone address / write data / read data    |
// |   ACK_I                 Wishbone acknowledge                         |
// |   bus_err               sticky: last Wishbone cycle timed out        |
// | Build option                                                         |
// |   SPI_WB_TIMEOUT_EN     abort a cycle after ACK_TIMEOUT clk without  |
// |                         ACK_I; otherwise wait forever, bus_err = 0   |
// +----------------------------------------------------------------------+
module spi_wb_bridge
    import spi_wb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        WE_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic [15:0] ADR_O,
    output logic [15:0] DAT_O,
    input  logic [15:0] DAT_I,
    input  logic        ACK_I,
    output logic        bus_err
);

    // SCK-rise counts at which each frame phase ends
    localparam logic [5:0] c_HDR_LAST  = 6'(HDR_BITS - 1);
    localparam logic [5:0] c_WR_LAST   = 6'(HDR_BITS + DATA_BITS - 1);
    localparam logic [5:0] c_DUMMY_END = 6'(HDR_BITS + DUMMY_BITS);
    localparam logic [5:0] c_RD_END    = 6'(HDR_BITS + DUMMY_BITS + DATA_BITS);

    generate
        if (SYNC_STAGES < 2 || ACK_TIMEOUT < 1) begin : g_cfg_unsupported
            // Configuration outside the supported range; nothing extra is
            // built, the bridge is simply not defined for it.
        end
    endgenerate

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_mosi_s;
    logic       w_cs_n_s;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_bit_cnt;
    logic [6:0] r_hdr;
    logic [6:0] r_addr;
    logic [15:0] r_dat;
    logic [15:0] r_tx;

    logic [7:0] w_hdr_full;
    logic       w_hdr_done;
    logic       w_in_bus;
    logic       w_counting;
    logic       w_timeout;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_rise (w_sclk_rise),
        .sclk_fall (w_sclk_fall),
        .cs_fall   (w_cs_fall),
        .cs_rise   (w_cs_rise),
        .mosi_s    (w_mosi_s),
        .cs_n_s    (w_cs_n_s)
    );

    assign w_hdr_full = {r_hdr, w_mosi_s};
    assign w_hdr_done = (r_state == c_HDR) && w_sclk_rise && (r_bit_cnt == c_HDR_LAST);
    assign w_in_bus   = (r_state == c_WR_BUS) || (r_state == c_RD_BUS);
    // The frame bit counter keeps running through RD_BUS so dummy clocks
    // are not lost while the slave is slow to acknowledge.
    assign w_counting = (r_state == c_HDR) || (r_state == c_WR_SHIFT) ||
                        (r_state == c_RD_BUS) || (r_state == c_RD_DUMMY) ||
                        (r_state == c_RD_SHIFT);

    // ------------------------------------------------------------------
    // Optional acknowledge timeout
    // ------------------------------------------------------------------
`ifdef SPI_WB_TIMEOUT_EN
    localparam int              c_TO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_bus_err;

    assign w_timeout = w_in_bus && !ACK_I && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_in_bus && !ACK_I && !w_timeout) begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end else begin
                r_to_cnt <= '0;
            end
            if ((r_state == c_IDLE) && w_cs_fall) begin
                r_bus_err <= 1'b0;
            end else if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_cs_fall) w_state_nxt = c_HDR;
            end
            c_HDR: begin
                if (w_cs_rise) begin
                    w_state_nxt = c_IDLE;
                end else if (w_hdr_done) begin
                    w_state_nxt = w_hdr_full[RW_BIT] ? c_WR_SHIFT : c_RD_BUS;
                end
            end
            c_WR_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = c_IDLE;
                end else if (w_sclk_rise && (r_bit_cnt == c_WR_LAST)) begin
                    w_state_nxt = c_WR_BUS;
                end
            end
            // A bus cycle always completes; CS_N is checked as a level so a
            // deselect seen during the cycle still lands us in IDLE.
            c_WR_BUS: begin
                if (ACK_I || w_timeout) begin
                    w_state_nxt = w_cs_n_s ? c_IDLE : c_WAIT_CS;
                end
            end
            c_RD_BUS: begin
                if (ACK_I || w_timeout) begin
                    w_state_nxt = w_cs_n_s ? c_IDLE : c_RD_DUMMY;
                end
            end
            c_RD_DUMMY: begin
                if (w_cs_rise) begin
                    w_state_nxt = c_IDLE;
                end else if (r_bit_cnt >= c_DUMMY_END) begin
                    w_state_nxt = c_RD_SHIFT;
                end
            end
            c_RD_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = c_IDLE;
                end else if (r_bit_cnt >= c_RD_END) begin
                    w_state_nxt = c_WAIT_CS;
                end
            end
            c_WAIT_CS: begin
                if (w_cs_rise) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        CYC_O = 1'b0;
        STB_O = 1'b0;
        WE_O  = 1'b0;
        miso  = 1'b0;
        case (r_state)
            c_WR_BUS: begin
                CYC_O = 1'b1;
                STB_O = 1'b1;
                WE_O  = 1'b1;
            end
            c_RD_BUS: begin
                CYC_O = 1'b1;
                STB_O = 1'b1;
            end
            c_RD_SHIFT: begin
                miso = r_tx[15];
            end
            default: ;
        endcase
    end

    assign miso_oe = ~w_cs_n_s;
    assign ADR_O   = {9'b0, r_addr};
    assign DAT_O   = r_dat;

    // ------------------------------------------------------------------
    // Datapath: bit counter, header/data shift, read-data shift
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_hdr     <= '0;
            r_addr    <= '0;
            r_dat     <= '0;
            r_tx      <= '0;
        end else begin
            if ((r_state == c_IDLE) && w_cs_fall) begin
                r_bit_cnt <= '0;
            end else if (w_counting && w_sclk_rise && (r_bit_cnt != 6'h3F)) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            if ((r_state == c_HDR) && w_sclk_rise) begin
                r_hdr <= w_hdr_full[6:0];
            end

            // Address is latched once per frame so it stays put through
            // the bus cycle. TX is cleared so a late ACK shifts out zeros.
            if (w_hdr_done) begin
                r_addr <= w_hdr_full[6:0];
                r_tx   <= '0;
            end

            if ((r_state == c_WR_SHIFT) && w_sclk_rise) begin
                r_dat <= {r_dat[14:0], w_mosi_s};
            end

            // Capture only if the dummy phase is still running; otherwise
            // the host is already clocking data out and gets zeros.
            if ((r_state == c_RD_BUS) && (ACK_I || w_timeout) &&
                (r_bit_cnt < c_DUMMY_END)) begin
                r_tx <= ACK_I ? DAT_I : TIMEOUT_DATA;
            end else if ((r_state == c_RD_SHIFT) && w_sclk_fall &&
                         (r_bit_cnt > c_DUMMY_END)) begin
                r_tx <= {r_tx[14:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_wb_bridge.md
# spi_wb_bridge

SPI slave to Wishbone master bridge for the audio front end. An external host (MCU/FPGA debug header) configures the front-end register file over SPI. The bridge deserialises each SPI frame and issues exactly one classic single-beat Wishbone cycle to the register file slave. For reads, it returns the register contents on MISO.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of the SCK/CS_N/MOSI synchronisers (≥2)
- ACK_TIMEOUT, 64, clk cycles to wait for ACK_I before aborting; used only with the timeout feature

Ports:
- clk  in  1  system clock; the single clock domain
- reset  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock (mode 0), asynchronous to clk
- cs_n  in  1  SPI chip select, active low, asynchronous
- mosi  in  1  SPI data in, asynchronous
- miso  out  1  SPI data out
- miso_oe  out  1  MISO output enable; high only while cs_n is sampled low
- WE_O  out  1  Wishbone write enable
- CYC_O  out  1  Wishbone cycle
- STB_O  out  1  Wishbone strobe
- ADR_O  out  16  Wishbone address
- DAT_O  out  16  Wishbone write data
- DAT_I  in  16  Wishbone read data
- ACK_I  in  1  Wishbone acknowledge
- bus_err  out  1  sticky: last Wishbone cycle timed out

## Operation
- Frame format, MSB first, SPI mode 0 (sample on SCK rise, shift on SCK fall):
  - Header byte: bit7 = 1 write / 0 read; bits6:0 = register address.
  - Write frame: header + 16 data bits (24 SCK).
  - Read frame: header + 8 dummy SCK + 16 data bits out (32 SCK).
- ADR_O = {9'b0, addr[6:0]}.
- FSM states:
  - IDLE → HDR on synchronised cs_n fall.
  - HDR: shift 8 bits. Write → WR_SHIFT; read → RD_BUS.
  - WR_SHIFT: shift 16 bits into DAT_O register → WR_BUS.
  - WR_BUS: CYC_O=STB_O=WE_O=1 until ACK_I sampled high → WAIT_CS.
  - RD_BUS: CYC_O=STB_O=1, WE_O=0. Capture DAT_I into the TX shift register in the ACK_I cycle → RD_DUMMY.
  - RD_DUMMY: wait until 8 dummy SCK rises have been counted → RD_SHIFT.
  - RD_SHIFT: drive 16 bits on MISO → WAIT_CS.
  - WAIT_CS: ignore further SCK; → IDLE on cs_n rise.
- Wishbone cycles are single classic cycles. CYC_O and STB_O assert and deassert together. ADR_O, DAT_O and WE_O are stable for the whole cycle.
- If the 8 dummy clocks finish before ACK_I, MISO shifts out 16'h0000.
- Partial write frame (cs_n rise before the 16th data bit) → no Wishbone cycle; return to IDLE.
- cs_n rise during WR_BUS/RD_BUS: finish the cycle (hold until ACK or timeout), then go to IDLE.
- bus_err clears at the start of the next header.

## Timing
- Reset values:
  - miso, miso_oe, WE_O, CYC_O, STB_O, bus_err: 0
  - ADR_O, DAT_O: 16'h0000
  - FSM: IDLE
- SCK edge detect latency: SYNC_STAGES+1 clk. MOSI is delayed identically, so it stays aligned.
- SCK frequency must be ≤ clk/8. cs_n-fall to first SCK rise must be ≥ 4 clk.
- CYC_O/STB_O assert 1 clk after the last header bit (read) or last data bit (write) is detected.
- Deassert in the clk after ACK_I is high; no back-to-back strobes.
- Read-data MSB is valid on MISO from the cycle after the 8th dummy rise is detected. Each later bit updates 1 clk after a detected SCK fall.
- miso_oe follows the synchronised ~cs_n.

## Configuration
- SPI_WB_TIMEOUT_EN defined:
  - A counter runs during WR_BUS/RD_BUS.
  - After ACK_TIMEOUT clk without ACK_I, drop CYC_O/STB_O and set bus_err.
  - A read then returns 16'hDEAD.
- Not defined: the bridge waits indefinitely for ACK_I; bus_err is tied 0.

## Structure
- Package spi_wb_pkg holds:
  - FSM state enum
  - HDR_BITS=8, DATA_BITS=16, DUMMY_BITS=8
  - RW_BIT index
  - TIMEOUT_DATA=16'hDEAD
- One sub-module, spi_edge_sync: SYNC_STAGES synchroniser for sclk/cs_n/mosi. Outputs sclk_rise, sclk_fall, cs_fall, cs_rise and mosi_s.

## Test plan
- Write frame 0x83,0xA5C3 → one Wishbone cycle: ADR_O=16'h0003, DAT_O=16'hA5C3, WE_O=1; CYC_O drops the clk after ACK_I.
- Read frame 0x03 + 8 dummy + 16 SCK, slave returns 16'hA5C3 with 1-clk ACK → MISO bits 1010_0101_1100_0011; WE_O=0 throughout.
- Write frame aborted by cs_n rise after 10 data bits → CYC_O never asserts; the next full frame works normally.
- With SPI_WB_TIMEOUT_EN, ACK_I held 0 on a read of 0x05 → CYC_O drops after 64 clk; bus_err=1; MISO returns 16'hDEAD. The next header clears bus_err.
- Back-to-back frames: write 0x81=0x1234, then read 0x01 with 4-clk cs_n gap → read returns 16'h1234.
- reset asserted mid-RD_SHIFT → next clk: all outputs 0, FSM IDLE; a following frame completes correctly.
